// File: rtl/game_pkg.sv
// Shared types and default constants for the two-player turn controller.
package game_pkg;

    localparam int unsigned POS_W            = 10;
    localparam int unsigned DEF_START_X      = 20;
    localparam int unsigned DEF_TILE_PX      = 60;
    localparam int unsigned DEF_FLAG_X       = 620;
    localparam int unsigned DEF_DONE_TIMEOUT = 1048576;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_SWITCH    = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_e;

    typedef enum logic {
        PLAYER1 = 1'b0,
        PLAYER2 = 1'b1
    } player_e;

    function automatic player_e other_player(input player_e p);
        return (p == PLAYER1) ? PLAYER2 : PLAYER1;
    endfunction

endpackage

// File: rtl/game_turn_ctrl_if.sv
// Request/turn-status bundle between the UI controller (master) and the turn controller (slave).
interface game_turn_ctrl_if;

    logic                      move_req;
    logic [1:0]                move_tiles;
    logic                      turn_done;
    logic                      pos_valid;
    game_pkg::player_e         active_player;
    logic [game_pkg::POS_W-1:0] player1_pos_x;
    logic [game_pkg::POS_W-1:0] player2_pos_x;
    logic                      busy;
    logic                      game_over;
    game_pkg::player_e         winner;
    logic                      timeout_err;

    modport master (
        output move_req, move_tiles, turn_done,
        input  pos_valid, active_player, player1_pos_x, player2_pos_x,
               busy, game_over, winner, timeout_err
    );

    modport slave (
        input  move_req, move_tiles, turn_done,
        output pos_valid, active_player, player1_pos_x, player2_pos_x,
               busy, game_over, winner, timeout_err
    );

endinterface

// File: rtl/pos_step_calc.sv
// Combinational position step: cur_x + tiles*TILE_PX, clamped to FLAG_X.
module pos_step_calc
    import game_pkg::*;
#(
    parameter int unsigned TILE_PX = DEF_TILE_PX,
    parameter int unsigned FLAG_X  = DEF_FLAG_X
) (
    input  logic [POS_W-1:0] cur_x,
    input  logic [1:0]       tiles,
    output logic [POS_W-1:0] next_x
);

    localparam int unsigned SUM_W = POS_W + 1;

    logic [SUM_W-1:0] sum;

    // Sum at one extra bit so an overshoot is seen before clamping to the flag.
    always_comb begin
        sum = {1'b0, cur_x} + ({{(SUM_W-2){1'b0}}, tiles} * SUM_W'(TILE_PX));
        if (sum > SUM_W'(FLAG_X)) begin
            next_x = POS_W'(FLAG_X);
        end else begin
            next_x = sum[POS_W-1:0];
        end
    end

endmodule

// File: rtl/game_turn_ctrl.sv
// Two-player turn sequencer: accepts a move, publishes the new position,
// waits for the UI to finish (or times out), then hands over or ends the game.
module game_turn_ctrl
    import game_pkg::*;
#(
    parameter int unsigned START_X      = DEF_START_X,
    parameter int unsigned TILE_PX      = DEF_TILE_PX,
    parameter int unsigned FLAG_X       = DEF_FLAG_X,
    parameter int unsigned DONE_TIMEOUT = DEF_DONE_TIMEOUT
) (
    input  logic            clk_100mhz,
    input  logic            btn_reset,
    game_turn_ctrl_if.slave bus
);

    localparam int unsigned      CNT_W   = $clog2(DONE_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DONE_TIMEOUT - 1);

    state_e           state_q, state_d;
    player_e          active_q, active_d;
    player_e          winner_q, winner_d;
    logic [POS_W-1:0] p1_q, p1_d;
    logic [POS_W-1:0] p2_q, p2_d;
    logic [1:0]       tiles_q, tiles_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pos_valid_q, pos_valid_d;
    logic             busy_q, busy_d;
    logic             game_over_q, game_over_d;
    logic             timeout_err_q, timeout_err_d;
    logic [POS_W-1:0] cur_x;
    logic [POS_W-1:0] step_x;

    assign cur_x = (active_q == PLAYER2) ? p2_q : p1_q;

    pos_step_calc #(
        .TILE_PX (TILE_PX),
        .FLAG_X  (FLAG_X)
    ) u_step (
        .cur_x  (cur_x),
        .tiles  (tiles_q),
        .next_x (step_x)
    );

    // Next-state and next-output logic for the turn FSM.
    always_comb begin
        state_d       = state_q;
        active_d      = active_q;
        winner_d      = winner_q;
        p1_d          = p1_q;
        p2_d          = p2_q;
        tiles_d       = tiles_q;
        cnt_d         = cnt_q;
        pos_valid_d   = 1'b0;
        busy_d        = busy_q;
        game_over_d   = game_over_q;
        timeout_err_d = timeout_err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.move_req && (bus.move_tiles != 2'd0)) begin
                    tiles_d = bus.move_tiles;
                    busy_d  = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (active_q == PLAYER2) begin
                    p2_d = step_x;
                end else begin
                    p1_d = step_x;
                end
                pos_valid_d = 1'b1;
                cnt_d       = '0;
                state_d     = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (bus.turn_done) begin
                    state_d = ST_SWITCH;
                end else if (cnt_q == CNT_MAX) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_SWITCH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SWITCH: begin
                busy_d = 1'b0;
                cnt_d  = '0;
                if (cur_x == POS_W'(FLAG_X)) begin
                    winner_d    = active_q;
                    game_over_d = 1'b1;
                    state_d     = ST_GAME_OVER;
                end else begin
                    active_d = other_player(active_q);
                    state_d  = ST_IDLE;
                end
            end
            ST_GAME_OVER: begin
                state_d = ST_GAME_OVER;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs, asynchronously cleared by btn_reset.
    always_ff @(posedge clk_100mhz or posedge btn_reset) begin
        if (btn_reset) begin
            state_q       <= ST_IDLE;
            active_q      <= PLAYER1;
            winner_q      <= PLAYER1;
            p1_q          <= POS_W'(START_X);
            p2_q          <= POS_W'(START_X);
            tiles_q       <= '0;
            cnt_q         <= '0;
            pos_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            game_over_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            active_q      <= active_d;
            winner_q      <= winner_d;
            p1_q          <= p1_d;
            p2_q          <= p2_d;
            tiles_q       <= tiles_d;
            cnt_q         <= cnt_d;
            pos_valid_q   <= pos_valid_d;
            busy_q        <= busy_d;
            game_over_q   <= game_over_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.pos_valid     = pos_valid_q;
    assign bus.active_player = active_q;
    assign bus.player1_pos_x = p1_q;
    assign bus.player2_pos_x = p2_q;
    assign bus.busy          = busy_q;
    assign bus.game_over     = game_over_q;
    assign bus.winner        = winner_q;
    assign bus.timeout_err   = timeout_err_q;

endmodule

// File: doc/game_turn_ctrl.md
GAME_TURN_CTRL -- requirements
Module: game_turn_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- START_X, 20, player x-coordinate after reset (px).
- TILE_PX, 60, pixels per tile step.
- FLAG_X, 620, flag x-coordinate; reaching it wins; positions never exceed it.
- DONE_TIMEOUT, 1048576, cycles to wait for turn_done before forcing turn end.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk_100mhz  in  1  sole clock, all logic on rising edge.
- btn_reset  in  1  asynchronous, active-high reset.
- move_req  in  1  one-cycle request to move the active player.
- move_tiles  in  2  tiles to move (1..3); 0 is invalid.
- turn_done  in  1  one-cycle pulse from the UI controller when the animation is finished.
- pos_valid  out  1  one-cycle pulse meaning new target position is published.
- active_player  out  1  0 = player1, 1 = player2; valid whenever pos_valid is high.
- player1_pos_x  out  10  player1 target x (px).
- player2_pos_x  out  10  player2 target x (px).
- busy  out  1  high from request acceptance until turn end.
- game_over  out  1  level; high once a player reaches FLAG_X.
- winner  out  1  winning player id; valid while game_over is high.
- timeout_err  out  1  sticky; set when a DONE_TIMEOUT expiry occurs.

Function
REQ-003 FSM states: IDLE, ISSUE, WAIT_DONE, SWITCH, GAME_OVER.
REQ-004 IDLE: move_req=1 with move_tiles!=0 is accepted; go to ISSUE; busy rises on the next edge.
REQ-005 move_req with move_tiles=0, or any move_req outside IDLE, is ignored with no state change.
REQ-006 ISSUE (one cycle): the active player's position becomes min(pos + move_tiles*TILE_PX, FLAG_X), computed at 11 bits before the clamp. pos_valid=1 in the same cycle the new position is visible. Next state is WAIT_DONE.
REQ-007 Latency: for an accepted move_req at edge N, pos_valid is high for exactly the cycle following edge N+1.
REQ-008 WAIT_DONE: the timeout counter starts from 0. On turn_done=1, go to SWITCH. If the counter reaches DONE_TIMEOUT-1, set timeout_err and go to SWITCH.
REQ-009 turn_done outside WAIT_DONE is ignored, including when it coincides with the ISSUE cycle.
REQ-010 SWITCH (one cycle):
- If the position just moved equals FLAG_X: winner=active_player, game_over=1, go to GAME_OVER.
- Otherwise: toggle active_player and go to IDLE.
- busy falls on leaving SWITCH.
REQ-011 GAME_OVER is absorbing. All move_req are ignored, positions are frozen, busy=0. Only reset exits this state.
REQ-012 The inactive player's position never changes during another player's turn.
REQ-013 pos_valid is never asserted outside ISSUE and is never high for two consecutive cycles.

Reset
REQ-014 btn_reset=1 asynchronously forces the following values, regardless of state, including mid-turn:
- state=IDLE, player1_pos_x=player2_pos_x=START_X, active_player=0.
- pos_valid=0, busy=0, game_over=0, winner=0, timeout_err=0, timeout counter=0.
REQ-015 The first accepted move_req after reset deassertion is serviced normally. No request captured before reset survives it.

Structure
REQ-016 A shared package game_pkg holds:
- the FSM state enum (3-bit encoding);
- the player-id typedef;
- default constants START_X, TILE_PX, FLAG_X.
REQ-017 The position add/clamp is a combinational sub-module pos_step_calc (inputs: cur_x, tiles; output: next_x). It is instantiated once, muxed by active_player.

Verification
REQ-018 Reset, then move_req with move_tiles=1 -> one pos_valid pulse with active_player=0, player1_pos_x=80; player2_pos_x stays 20.
REQ-019 turn_done pulse, then move_req with move_tiles=3 -> active_player=1, player2_pos_x=200, player1_pos_x stays 80.
REQ-020 move_req while busy, move_tiles=0 in IDLE, and turn_done in IDLE -> no pos_valid, positions unchanged, state unchanged.
REQ-021 Player1 at 560, move_tiles=3 -> player1_pos_x=620 (clamped). After turn_done: game_over=1, winner=0. Further move_req -> no pos_valid.
REQ-022 Bench with DONE_TIMEOUT=16 and no turn_done -> timeout_err=1 exactly 16 cycles into WAIT_DONE, active_player toggles, busy falls.
REQ-023 btn_reset asserted during WAIT_DONE -> all outputs at the REQ-014 values within the same cycle. A following move_tiles=2 gives player1_pos_x=140.
